// File: rtl/button_evt_pkg.sv
// Shared types for the button event scheduler: FSM states, event kinds and
// the event-id width rule.
package button_evt_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

   typedef enum logic {
      EVT_PRESS = 1'b0,
      EVT_LONG  = 1'b1
   } evt_kind_t;

   // Event id width: enough bits to index every button, never less than one.
   function automatic int id_width(input int num_buttons);
      return (num_buttons > 1) ? $clog2(num_buttons) : 1;
   endfunction

endpackage

// File: rtl/button_event_scheduler_if.sv
// Valid/ready event port shared by all buttons; the scheduler drives the
// master side, the control FSM sits on the slave side.
interface button_event_scheduler_if #(
   parameter int ID_W = 3
) ();

   logic            evt_valid;
   logic            evt_ready;
   logic [ID_W-1:0] evt_id;
   logic            evt_long;

   modport master (
      output evt_valid,
      output evt_id,
      output evt_long,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_id,
      input  evt_long,
      output evt_ready
   );

endinterface

// File: rtl/btn_hold_timer.sv
// Per-button hold counter: counts cycles the level stays high, saturates at
// HOLD_CYCLES and strobes once on the edge that reaches the limit.
module btn_hold_timer #(
   parameter int HOLD_CYCLES = 100000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic long_strobe
);

   localparam int                CNT_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (!btn) begin
         cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Saturation at CNT_MAX keeps this to one strobe per continuous hold.
   assign long_strobe = btn && (cnt_q == CNT_LAST);

endmodule

// File: rtl/button_event_scheduler.sv
// Turns debounced button levels into press / long-press events, latches them
// as pending and presents them one at a time on a round-robin valid/ready port.
module button_event_scheduler
   import button_evt_pkg::*;
#(
   parameter int NUM_BUTTONS = 5,
   parameter int HOLD_CYCLES = 100000000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_BUTTONS-1:0]    btn_in,
   button_event_scheduler_if.master  evt,
   output logic                      overflow,
   input  logic                      overflow_clr
);

   localparam int ID_W = id_width(NUM_BUTTONS);

   logic [NUM_BUTTONS-1:0] btn_prev_q;
   logic                   primed_q;
   logic [NUM_BUTTONS-1:0] press_set;
   logic [NUM_BUTTONS-1:0] long_set;
   logic [NUM_BUTTONS-1:0] press_pend_q;
   logic [NUM_BUTTONS-1:0] long_pend_q;
   logic [NUM_BUTTONS-1:0] press_grant;
   logic [NUM_BUTTONS-1:0] long_grant;
   logic [NUM_BUTTONS-1:0] press_drop;
   logic [NUM_BUTTONS-1:0] long_drop;

   state_t          state_q;
   state_t          state_d;
   logic            grant;
   logic [ID_W-1:0] rr_q;
   logic            win_found;
   logic [ID_W-1:0] win_id;
   evt_kind_t       win_kind;
   logic [ID_W:0]   scan;
   logic [ID_W-1:0] id_q;
   evt_kind_t       kind_q;
   logic            ovf_q;

   // NOTE: every clocked process uses non-blocking assignments so all flops
   // sample the same pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_prev_q <= '0;
         primed_q   <= 1'b0;
      end else begin
         btn_prev_q <= btn_in;
         primed_q   <= 1'b1;
      end
   end

   // Until primed, btn_prev_q is not a real history, so a button held through
   // reset must not look like a fresh press.
   assign press_set = primed_q ? (btn_in & ~btn_prev_q) : '0;

   generate
      if (HOLD_CYCLES > 0) begin : g_long
         for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_timer
            btn_hold_timer #(
               .HOLD_CYCLES (HOLD_CYCLES)
            ) u_timer (
               .clk         (clk),
               .rst         (rst),
               .btn         (btn_in[i]),
               .long_strobe (long_set[i])
            );
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               long_pend_q <= '0;
            end else begin
               long_pend_q <= (long_pend_q & ~long_grant) | long_set;
            end
         end
      end else begin : g_no_long
         assign long_set    = '0;
         assign long_pend_q = '0;
      end
   endgenerate

   // A set that lands on the bit being granted in the same edge is kept, not dropped.
   assign press_drop = press_set & press_pend_q & ~press_grant;
   assign long_drop  = long_set  & long_pend_q  & ~long_grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         press_pend_q <= '0;
      end else begin
         press_pend_q <= (press_pend_q & ~press_grant) | press_set;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (|press_drop || |long_drop) begin
         ovf_q <= 1'b1;
      end else if (overflow_clr) begin
         ovf_q <= 1'b0;
      end
   end

   // NOTE: every signal written in an always_comb gets a default on entry so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      win_kind  = EVT_PRESS;
      scan      = '0;
      for (int k = 1; k <= NUM_BUTTONS; k++) begin
         scan = {1'b0, rr_q} + (ID_W+1)'(k);
         if (scan >= (ID_W+1)'(NUM_BUTTONS)) begin
            scan = scan - (ID_W+1)'(NUM_BUTTONS);
         end
         if (!win_found && (press_pend_q[scan[ID_W-1:0]] || long_pend_q[scan[ID_W-1:0]])) begin
            win_found = 1'b1;
            win_id    = scan[ID_W-1:0];
            win_kind  = press_pend_q[scan[ID_W-1:0]] ? EVT_PRESS : EVT_LONG;
         end
      end
   end

   always_comb begin
      press_grant = '0;
      long_grant  = '0;
      if (grant) begin
         if (win_kind == EVT_PRESS) begin
            press_grant[win_id] = 1'b1;
         end else begin
            long_grant[win_id] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               grant   = 1'b1;
               state_d = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (evt.evt_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rr_q    <= ID_W'(NUM_BUTTONS - 1);
         id_q    <= '0;
         kind_q  <= EVT_PRESS;
      end else begin
         state_q <= state_d;
         if (grant) begin
            rr_q   <= win_id;
            id_q   <= win_id;
            kind_q <= win_kind;
         end
      end
   end

   assign evt.evt_valid = (state_q == ST_PRESENT);
   assign evt.evt_id    = id_q;
   assign evt.evt_long  = (kind_q == EVT_LONG);
   assign overflow      = ovf_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Self-checking bench: a cycle-level event model runs alongside the DUT with
// directed scenarios pinned by literal expectations, then randomized traffic.
module tb_button_event_scheduler;
   import button_evt_pkg::*;

   localparam int N    = 5;
   localparam int H    = 20;
   localparam int ID_W = id_width(N);

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] btn_in;
   logic         overflow;
   logic         overflow_clr;

   button_event_scheduler_if #(.ID_W(ID_W)) evt_if ();

   button_event_scheduler #(
      .NUM_BUTTONS (N),
      .HOLD_CYCLES (H)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_in       (btn_in),
      .evt          (evt_if),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int cyc;
      int id;
      bit lng;
   } ev_t;
   ev_t log_q[$];

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_ev(input string name, input int k, input int exp_cyc,
                           input int exp_id, input bit exp_long);
      if (k >= log_q.size()) begin
         check({name, " present"}, 64'(log_q.size()), 64'(k + 1));
      end else begin
         check({name, " cycle"}, 64'(log_q[k].cyc), 64'(exp_cyc));
         check({name, " id"},    64'(log_q[k].id),  64'(exp_id));
         check({name, " long"},  64'(log_q[k].lng), 64'(exp_long));
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Behavioural model: pending events per button, one presented event, rr pointer.
   bit         m_primed;
   bit [N-1:0] m_prev;
   int         m_len   [N];
   bit         m_press [N];
   bit         m_long  [N];
   bit         m_busy;
   int         m_id;
   bit         m_lng;
   int         m_rr;
   bit         m_ovf;

   task automatic model_step();
      int gi;
      bit g_long;
      bit drop;
      int idx;
      bit p_new, l_new, p_gnt, l_gnt;
      gi     = -1;
      g_long = 1'b0;
      drop   = 1'b0;
      if (!m_busy) begin
         for (int k = 1; k <= N; k++) begin
            idx = (m_rr + k) % N;
            if (gi < 0 && (m_press[idx] || m_long[idx])) begin
               gi     = idx;
               g_long = !m_press[idx];
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         p_new = m_primed && btn_in[i] && !m_prev[i];
         l_new = btn_in[i] && (m_len[i] + 1 == H);
         p_gnt = (gi == i) && !g_long;
         l_gnt = (gi == i) && g_long;
         if (p_new && m_press[i] && !p_gnt) drop = 1'b1;
         if (l_new && m_long[i] && !l_gnt) drop = 1'b1;
         m_press[i] = p_new || (m_press[i] && !p_gnt);
         m_long[i]  = l_new || (m_long[i] && !l_gnt);
         m_len[i]   = btn_in[i] ? ((m_len[i] < H) ? m_len[i] + 1 : H) : 0;
      end
      if (drop) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
      if (m_busy && evt_if.evt_ready) begin
         m_busy = 1'b0;
      end else if (gi >= 0) begin
         m_busy = 1'b1;
         m_id   = gi;
         m_lng  = g_long;
         m_rr   = gi;
      end
      m_prev   = btn_in;
      m_primed = 1'b1;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_primed = 1'b0;
         m_prev   = '0;
         m_busy   = 1'b0;
         m_id     = 0;
         m_lng    = 1'b0;
         m_rr     = N - 1;
         m_ovf    = 1'b0;
         for (int i = 0; i < N; i++) begin
            m_len[i]   = 0;
            m_press[i] = 1'b0;
            m_long[i]  = 1'b0;
         end
      end else begin
         model_step();
      end
   end

   // Per-cycle comparison against the model, plus a log of accepted events.
   always @(negedge clk) begin
      ev_t e;
      check("evt_valid", 64'(evt_if.evt_valid), 64'(m_busy));
      if (m_busy) begin
         check("evt_id",   64'(evt_if.evt_id),   64'(m_id));
         check("evt_long", 64'(evt_if.evt_long), 64'(m_lng));
      end
      check("overflow", 64'(overflow), 64'(m_ovf));
      if (!rst && evt_if.evt_valid && evt_if.evt_ready) begin
         e.cyc = cyc;
         e.id  = int'(evt_if.evt_id);
         e.lng = evt_if.evt_long;
         log_q.push_back(e);
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(2);
      log_q.delete();
   endtask

   initial begin
      int t;
      int r;
      rst              = 1'b0;
      btn_in           = '0;
      overflow_clr     = 1'b0;
      evt_if.evt_ready = 1'b0;
      #1 rst = 1'b1;
      step(3);
      check("reset evt_valid", 64'(evt_if.evt_valid), 64'd0);
      check("reset evt_id",    64'(evt_if.evt_id),    64'd0);
      check("reset evt_long",  64'(evt_if.evt_long),  64'd0);
      check("reset overflow",  64'(overflow),         64'd0);
      rst = 1'b0;
      step(2);

      // Single press on button 2: presented two cycles after the edge.
      do_reset();
      evt_if.evt_ready = 1'b1;
      t = cyc;
      btn_in[2] = 1'b1;
      step(5);
      btn_in[2] = 1'b0;
      step(5);
      check("single count", 64'(log_q.size()), 64'd1);
      check_ev("single ev0", 0, t + 2, 2, 1'b0);
      check("single overflow", 64'(overflow), 64'd0);

      // Round robin from rr=4, then wrap from rr=3.
      do_reset();
      t = cyc;
      btn_in = 5'b01011;
      step(4);
      btn_in = '0;
      step(4);
      check("rr count", 64'(log_q.size()), 64'd3);
      check_ev("rr ev0", 0, t + 2, 0, 1'b0);
      check_ev("rr ev1", 1, t + 4, 1, 1'b0);
      check_ev("rr ev2", 2, t + 6, 3, 1'b0);
      log_q.delete();
      t = cyc;
      btn_in = 5'b01001;
      step(4);
      btn_in = '0;
      step(4);
      check("wrap count", 64'(log_q.size()), 64'd2);
      check_ev("wrap ev0", 0, t + 2, 0, 1'b0);
      check_ev("wrap ev1", 1, t + 4, 3, 1'b0);

      // Long press on button 4 held for 50 cycles.
      log_q.delete();
      t = cyc;
      btn_in[4] = 1'b1;
      step(50);
      btn_in[4] = 1'b0;
      step(5);
      check("long count", 64'(log_q.size()), 64'd2);
      check_ev("long ev0", 0, t + 2,  4, 1'b0);
      check_ev("long ev1", 1, t + 21, 4, 1'b1);

      // Backpressure: one presented, one pending, the third press dropped.
      log_q.delete();
      evt_if.evt_ready = 1'b0;
      t = cyc;
      btn_in[1] = 1'b1;
      step(1);
      btn_in[1] = 1'b0;
      step(2);
      btn_in[1] = 1'b1;
      step(1);
      btn_in[1] = 1'b0;
      step(1);
      btn_in[1] = 1'b1;
      step(1);
      btn_in[1] = 1'b0;
      step(2);
      check("bp valid held", 64'(evt_if.evt_valid), 64'd1);
      check("bp id held",    64'(evt_if.evt_id),    64'd1);
      check("bp overflow",   64'(overflow),         64'd1);
      evt_if.evt_ready = 1'b1;
      step(6);
      check("bp count", 64'(log_q.size()), 64'd2);
      check_ev("bp ev0", 0, t + 8,  1, 1'b0);
      check_ev("bp ev1", 1, t + 10, 1, 1'b0);
      check("bp overflow sticky", 64'(overflow), 64'd1);
      overflow_clr = 1'b1;
      step(1);
      overflow_clr = 1'b0;
      check("bp overflow cleared", 64'(overflow), 64'd0);

      // Button 0 held through reset release: only the long event appears.
      rst = 1'b1;
      btn_in = 5'b00001;
      step(2);
      log_q.delete();
      rst = 1'b0;
      r = cyc;
      step(30);
      btn_in = '0;
      step(3);
      check("held count", 64'(log_q.size()), 64'd1);
      check_ev("held ev0", 0, r + 21, 0, 1'b1);

      // Reset while an event is presented.
      evt_if.evt_ready = 1'b0;
      btn_in[3] = 1'b1;
      step(3);
      check("mid valid before rst", 64'(evt_if.evt_valid), 64'd1);
      rst = 1'b1;
      #1;
      check("mid valid after rst",    64'(evt_if.evt_valid), 64'd0);
      check("mid overflow after rst", 64'(overflow),         64'd0);
      step(2);
      btn_in = '0;
      rst = 1'b0;
      step(2);

      // Re-press of button 2 on the very edge its pending press is granted.
      do_reset();
      evt_if.evt_ready = 1'b0;
      t = cyc;
      btn_in[0] = 1'b1;
      step(1);
      btn_in[0] = 1'b0;
      btn_in[2] = 1'b1;
      step(1);
      btn_in[2] = 1'b0;
      step(3);
      evt_if.evt_ready = 1'b1;
      step(1);
      btn_in[2] = 1'b1;
      step(1);
      btn_in[2] = 1'b0;
      step(6);
      check("coll count", 64'(log_q.size()), 64'd3);
      check_ev("coll ev0", 0, t + 5, 0, 1'b0);
      check_ev("coll ev1", 1, t + 7, 2, 1'b0);
      check_ev("coll ev2", 2, t + 9, 2, 1'b0);
      check("coll overflow", 64'(overflow), 64'd0);

      // Randomized traffic, checked every cycle against the model.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 11) == 0) btn_in[i] = ~btn_in[i];
         end
         evt_if.evt_ready = ($urandom_range(0, 9) < 6);
         overflow_clr     = ($urandom_range(0, 23) == 0);
         rst              = ($urandom_range(0, 799) == 0);
         step(1);
      end
      rst          = 1'b0;
      overflow_clr = 1'b0;
      step(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
